// File: rtl/float_to_fix_mc_pkg.sv
// Shared types and IEEE-754 single-precision field widths
// for the multi-channel float to fixed converter.
package f2f_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  typedef enum logic {
    RND_RNE,
    RND_TRUNC
  } rnd_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_HOLD
  } f2f_state_t;

endpackage

// File: rtl/float_to_fix_mc_if.sv
// Valid/ready bundle between float front-end, converter
// and fixed-point consumer.
interface float_to_fix_mc_if #(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4,
  parameter int N_CH        = 3
);
  localparam int T = INT_WIDTH + FRACT_WIDTH;

  logic              in_valid;
  logic              in_ready;
  logic [32*N_CH-1:0] in_data;
  logic              in_rnd_mode;
  logic              out_valid;
  logic              out_ready;
  logic [T*N_CH-1:0] out_data;
  logic [N_CH-1:0]   out_ovf;
  logic [N_CH-1:0]   out_nan;
  logic              busy;

  modport master (
    output in_valid, in_data, in_rnd_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_nan, busy
  );

  modport slave (
    input  in_valid, in_data, in_rnd_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_nan, busy
  );

endinterface

// File: rtl/float_to_fix_core.sv
// Combinational single-channel float to signed fixed-point
// conversion with RNE/truncate rounding and saturation.
module float_to_fix_core
  import f2f_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic [31:0]                      float,
  input  rnd_mode_t                        rnd_mode,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] fixed,
  output logic                             ovf,
  output logic                             nan
);

  localparam int T  = INT_WIDTH + FRACT_WIDTH;
  localparam int GS = 26;
  localparam int WW = T + 1 + GS;
  localparam int SH_OFF = EXP_BIAS + MAN_W - FRACT_WIDTH;

  localparam logic signed [11:0] SH_BIG   = 12'(T - MAN_W);
  localparam logic signed [11:0] SH_SMALL = -12'sd26;
  localparam logic [T+1:0] POS_MAX = (T+2)'((1 << (T-1)) - 1);
  localparam logic [T+1:0] NEG_MAX = (T+2)'(1 << (T-1));

  logic                 sgn;
  logic [EXP_W-1:0]     ex;
  logic [MAN_W-1:0]     man;
  logic [MAN_W:0]       sig;
  logic signed [11:0]   sh;
  logic [11:0]          lsh;
  logic [WW-1:0]        acc;
  logic [T:0]           mag;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [T+1:0]         magr;
  logic [T-1:0]         low;

  always_comb begin
    sgn    = float[31];
    ex     = float[30:23];
    man    = float[22:0];
    sig    = {1'b1, man};
    sh     = $signed({4'b0, ex}) - $signed(12'(SH_OFF));
    lsh    = 12'(sh - SH_SMALL);
    acc    = '0;
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    inc    = 1'b0;
    magr   = '0;
    low    = '0;
    fixed  = '0;
    ovf    = 1'b0;
    nan    = 1'b0;

    if (ex == '1) begin
      nan = |man;
      ovf = ~nan;
      if (!nan) fixed = sgn ? NEG_MAX[T-1:0] : POS_MAX[T-1:0];
    end else if (ex != '0) begin
      // Shifts beyond SH_BIG exceed 2^(T+1) and cannot wrap.
      if (sh > SH_BIG) begin
        ovf = 1'b1;
      end else begin
        if (sh < SH_SMALL) begin
          sticky = 1'b1;
        end else begin
          acc    = WW'(sig) << lsh;
          mag    = acc[WW-1:GS];
          guard  = acc[GS-1];
          sticky = |acc[GS-2:0];
        end
        inc  = (rnd_mode == RND_RNE) & guard & (sticky | mag[0]);
        magr = {1'b0, mag} + (T+2)'(inc);
        ovf  = sgn ? (magr > NEG_MAX) : (magr > POS_MAX);
      end
      low = magr[T-1:0];
      if (ovf) fixed = sgn ? NEG_MAX[T-1:0] : POS_MAX[T-1:0];
      else     fixed = sgn ? (~low + 1'b1) : low;
    end
  end

endmodule

// File: rtl/float_to_fix_mc.sv
// Multi-channel converter: latches a float vector, runs it
// through one shared core a channel per cycle, holds result.
module float_to_fix_mc
  import f2f_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4,
  parameter int N_CH        = 3
) (
  input  logic              clk,
  input  logic              rst,
  float_to_fix_mc_if.slave  bus
);

  localparam int T  = INT_WIDTH + FRACT_WIDTH;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  f2f_state_t      state;
  logic [IW-1:0]   idx;
  logic [31:0]     in_q  [N_CH];
  rnd_mode_t       mode_q;
  logic [T-1:0]    res_q [N_CH];
  logic [N_CH-1:0] ovf_q;
  logic [N_CH-1:0] nan_q;

  logic [T-1:0]    core_fix;
  logic            core_ovf;
  logic            core_nan;
  logic            acc_fire;

  float_to_fix_core #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_core (
    .float    (in_q[idx]),
    .rnd_mode (mode_q),
    .fixed    (core_fix),
    .ovf      (core_ovf),
    .nan      (core_nan)
  );

  assign bus.in_ready  = (state == S_IDLE) |
                         ((state == S_HOLD) & bus.out_ready);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_ovf   = ovf_q;
  assign bus.out_nan   = nan_q;
  assign acc_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N_CH; i++)
      bus.out_data[T*i +: T] = res_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      mode_q <= RND_RNE;
      ovf_q  <= '0;
      nan_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        in_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      // A new vector may enter from IDLE or straight out of HOLD.
      if (acc_fire) begin
        for (int i = 0; i < N_CH; i++)
          in_q[i] <= bus.in_data[32*i +: 32];
        mode_q <= rnd_mode_t'(bus.in_rnd_mode);
        idx    <= '0;
      end
      case (state)
        S_IDLE: begin
          if (acc_fire) state <= S_CONV;
        end
        S_CONV: begin
          res_q[idx] <= core_fix;
          ovf_q[idx] <= core_ovf;
          nan_q[idx] <= core_nan;
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready)
            state <= acc_fire ? S_CONV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fix_mc.sv
// Directed and randomised checks for float_to_fix_mc
// (INT=12, FRACT=4, N_CH=3).
module tb_float_to_fix_mc;

  localparam int T = 16;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   acc_cyc = 0;

  float_to_fix_mc_if #(.INT_WIDTH(12), .FRACT_WIDTH(4), .N_CH(N)) bus ();

  float_to_fix_mc #(.INT_WIDTH(12), .FRACT_WIDTH(4), .N_CH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void model(input logic [31:0] f, input logic m,
                                output logic [15:0] r, output logic ov,
                                output logic na);
    real    a, ip, fr;
    int     n;
    longint q, v;
    r = '0; ov = 1'b0; na = 1'b0;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 0) na = 1'b1;
      else begin ov = 1'b1; r = f[31] ? 16'h8000 : 16'h7FFF; end
    end else if (f[30:23] != 8'h00) begin
      a = real'({1'b1, f[22:0]});
      n = int'(f[30:23]) - 146;
      for (int i = 0; i < n; i++) a = a * 2.0;
      for (int i = 0; i > n; i--) a = a / 2.0;
      if (a >= 65536.0) begin
        ov = 1'b1; r = f[31] ? 16'h8000 : 16'h7FFF;
      end else begin
        ip = $floor(a);
        fr = a - ip;
        q  = longint'($rtoi(ip));
        if (!m && (fr > 0.5 || (fr == 0.5 && q[0]))) q++;
        v = f[31] ? -q : q;
        if (v > 32767)       begin ov = 1'b1; r = 16'h7FFF; end
        else if (v < -32768) begin ov = 1'b1; r = 16'h8000; end
        else r = v[15:0];
      end
    end
  endfunction

  task automatic send_vec(input logic [95:0] d, input logic m);
    @(negedge clk);
    bus.in_data = d;
    bus.in_rnd_mode = m;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    if (!bus.in_ready) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL accept_timeout in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
    if (!bus.out_valid) @(negedge clk);
    lat = cyc - acc_cyc;
    if (!bus.out_valid) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL out_timeout out_valid=%b want 1", bus.out_valid);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      miss_cnt++;
      $display("FAIL reset_ctl got %b want 100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    vec_cnt++;
    if ({bus.out_data, bus.out_ovf, bus.out_nan} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_data got %h/%b/%b want 0",
               bus.out_data, bus.out_ovf, bus.out_nan);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    send_vec({32'h00000000, 32'hC0100000, 32'h3FC00000}, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if (lat !== 3) begin
      miss_cnt++;
      $display("FAIL basic_latency got %0d want 3", lat);
    end
    vec_cnt++;
    if (bus.out_data !== 48'h0000_FFDC_0018) begin
      miss_cnt++;
      $display("FAIL basic_data got %h want 0000ffdc0018", bus.out_data);
    end
    vec_cnt++;
    if ({bus.out_ovf, bus.out_nan} !== 6'b0) begin
      miss_cnt++;
      $display("FAIL basic_flags got %b want 0", {bus.out_ovf, bus.out_nan});
    end
    drain();
    vec_cnt++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      miss_cnt++;
      $display("FAIL basic_idle got %b want 001",
               {bus.out_valid, bus.busy, bus.in_ready});
    end
  endtask

  task automatic test_rounding();
    int lat;
    logic [95:0] d;
    d = {32'hBDC00000, 32'h3E200000, 32'h3DC00000};
    send_vec(d, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if (bus.out_data !== 48'hFFFE_0002_0002) begin
      miss_cnt++;
      $display("FAIL round_rne got %h want fffe00020002", bus.out_data);
    end
    drain();
    send_vec(d, 1'b1);
    wait_out(lat);
    vec_cnt++;
    if (bus.out_data !== 48'hFFFF_0002_0001) begin
      miss_cnt++;
      $display("FAIL round_trunc got %h want ffff00020001", bus.out_data);
    end
    drain();
  endtask

  task automatic test_limits();
    int lat;
    send_vec({32'h7F800000, 32'hC5000000, 32'h45800000}, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if ({bus.out_data, bus.out_ovf, bus.out_nan} !==
        {48'h7FFF_8000_7FFF, 3'b101, 3'b000}) begin
      miss_cnt++;
      $display("FAIL limits_sat got %h/%b/%b want 7fff80007fff/101/000",
               bus.out_data, bus.out_ovf, bus.out_nan);
    end
    drain();
    send_vec({32'h80000000, 32'h00000001, 32'h7FC00000}, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if ({bus.out_data, bus.out_ovf, bus.out_nan} !==
        {48'h0, 3'b000, 3'b001}) begin
      miss_cnt++;
      $display("FAIL limits_nan got %h/%b/%b want 0/000/001",
               bus.out_data, bus.out_ovf, bus.out_nan);
    end
    drain();
    send_vec({32'h44FFFFFF, 32'hFF800000, 32'h44FFFFFF}, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if ({bus.out_data, bus.out_ovf} !== {48'h7FFF_8000_7FFF, 3'b111}) begin
      miss_cnt++;
      $display("FAIL limits_carry_rne got %h/%b want 7fff80007fff/111",
               bus.out_data, bus.out_ovf);
    end
    drain();
    send_vec({32'h44FFFFFF, 32'hFF800000, 32'h44FFFFFF}, 1'b1);
    wait_out(lat);
    vec_cnt++;
    if ({bus.out_data, bus.out_ovf} !== {48'h7FFF_8000_7FFF, 3'b010}) begin
      miss_cnt++;
      $display("FAIL limits_carry_trunc got %h/%b want 7fff80007fff/010",
               bus.out_data, bus.out_ovf);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    send_vec({32'h40000000, 32'hBF800000, 32'h3F000000}, 1'b0);
    wait_out(lat);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_data !== 48'h0020_FFF0_0008) bad++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0) begin
      miss_cnt++;
      $display("FAIL hold_stable got %0d bad cycles want 0 (data %h)",
               bad, bus.out_data);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_rnd_mode = 1'b0;
    bus.in_data = {32'h00000000, 32'h41200000, 32'hC1200000};
    #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL hold_in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    vec_cnt++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b010) begin
      miss_cnt++;
      $display("FAIL b2b_conv got %b want 010",
               {bus.out_valid, bus.busy, bus.in_ready});
    end
    wait_out(lat);
    vec_cnt++;
    if (lat !== 3 || bus.out_data !== 48'h0000_00A0_FF60) begin
      miss_cnt++;
      $display("FAIL b2b_data got %h lat %0d want 000000a0ff60 lat 3",
               bus.out_data, lat);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_vec({32'h41200000, 32'h41200000, 32'h41200000}, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      miss_cnt++;
      $display("FAIL rst_mid_ctl got %b want 010",
               {bus.out_valid, bus.in_ready, bus.busy});
    end
    vec_cnt++;
    if (bus.out_data !== 48'h0) begin
      miss_cnt++;
      $display("FAIL rst_mid_data got %h want 0", bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    send_vec({32'h3F000000, 32'h00000000, 32'h3FC00000}, 1'b0);
    wait_out(lat);
    vec_cnt++;
    if (lat !== 3 || bus.out_data !== 48'h0008_0000_0018) begin
      miss_cnt++;
      $display("FAIL rst_fresh got %h lat %0d want 000800000018 lat 3",
               bus.out_data, lat);
    end
    drain();
  endtask

  task automatic test_random();
    logic [47:0] exp_d;
    logic [2:0]  exp_o, exp_n;
    logic [15:0] r;
    logic        ov, na, m;
    logic [31:0] f;
    logic [95:0] d;
    int          last = 0;
    int          cls;
    for (int k = 0; k <= 10000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
            cyc - last !== 3) begin
          miss_cnt++;
          $display("FAIL rnd_ctl k=%0d valid %b ready %b cyc %0d want 1 1 3",
                   k, bus.out_valid, bus.in_ready, cyc - last);
        end
        vec_cnt++;
        if ({bus.out_data, bus.out_ovf, bus.out_nan} !==
            {exp_d, exp_o, exp_n}) begin
          miss_cnt++;
          $display("FAIL rnd_data k=%0d got %h/%b/%b want %h/%b/%b", k,
                   bus.out_data, bus.out_ovf, bus.out_nan,
                   exp_d, exp_o, exp_n);
        end
      end
      if (k == 10000) break;
      m = 1'($urandom_range(0, 1));
      for (int c = 0; c < N; c++) begin
        f = $urandom;
        cls = $urandom_range(0, 15);
        if (cls == 0)      f[30:23] = 8'h00;
        else if (cls == 1) f[30:23] = 8'hFF;
        else if (cls > 2)  f[30:23] = 8'($urandom_range(110, 142));
        d[32*c +: 32] = f;
        model(f, m, r, ov, na);
        exp_d[16*c +: 16] = r;
        exp_o[c] = ov;
        exp_n[c] = na;
      end
      bus.in_data = d;
      bus.in_rnd_mode = m;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (k > 0) begin
        vec_cnt++;
        if (cyc - acc_cyc !== 4) begin
          miss_cnt++;
          $display("FAIL rnd_throughput k=%0d got %0d cycles want 4",
                   k, cyc - acc_cyc);
        end
      end
      acc_cyc = cyc;
      last = cyc;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      last = last;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_rnd_mode = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_limits();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
